// File: rtl/pipeline_issue_ctrl.sv
// Issue/warm-up controller for the entropy-encoder pipeline.
// Throttles symbol entry, tracks stage valids, primes carry, drains on flush.
module pipeline_issue_ctrl #(
  parameter int N_STAGES  = 3,
  parameter int ISSUE_GAP = 1
) (
  input  logic                clk,
  input  logic                reset_ctrl_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                flush,
  output logic [N_STAGES-1:0] stage_en,
  output logic                out_valid,
  output logic                carry_ctrl,
  output logic                busy,
  output logic                drain_done
);

  localparam int FW = $clog2(N_STAGES + 1);
  localparam int GW = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;
  localparam logic [FW-1:0] FILL_MAX = FW'(N_STAGES);
  localparam logic [GW-1:0] GAP_LD = GW'(ISSUE_GAP);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    DRAIN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [N_STAGES-1:0] vld;
  logic [N_STAGES-1:0] vld_nxt;
  logic [FW-1:0]       fill_cnt;
  logic [FW-1:0]       fill_nxt;
  logic [GW-1:0]       gap_cnt;
  logic                accept;

  assign in_ready  = (state != DRAIN) && (gap_cnt == '0);
  assign accept    = in_valid & in_ready;
  assign stage_en  = vld;
  assign out_valid = vld[N_STAGES-1];
  assign busy      = (state != IDLE) | (|vld);

  generate
    if (N_STAGES == 1) begin : g_one
      assign vld_nxt = accept;
    end else begin : g_shift
      assign vld_nxt = {vld[N_STAGES-2:0], accept};
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    fill_nxt  = fill_cnt;
    unique case (state)
      IDLE, FILL: begin
        if (accept && fill_cnt != FILL_MAX)
          fill_nxt = fill_cnt + FW'(1);
        if (flush)
          state_nxt = DRAIN;
        else if (accept)
          state_nxt = (fill_nxt == FILL_MAX) ? RUN : FILL;
      end
      RUN: begin
        if (flush)
          state_nxt = DRAIN;
      end
      DRAIN: begin
        if (vld == '0) begin
          state_nxt = IDLE;
          fill_nxt  = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_ctrl_n) begin
    if (!reset_ctrl_n) begin
      state      <= IDLE;
      vld        <= '0;
      fill_cnt   <= '0;
      gap_cnt    <= '0;
      carry_ctrl <= 1'b0;
      drain_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      vld      <= vld_nxt;
      fill_cnt <= fill_nxt;
      if (accept)
        gap_cnt <= GAP_LD;
      else if (gap_cnt != '0)
        gap_cnt <= gap_cnt - GW'(1);
      // carry survives a drain entered from RUN so in-flight symbols finish
      carry_ctrl <= (state_nxt == RUN) |
                    ((state_nxt == DRAIN) & carry_ctrl);
      drain_done <= (state == DRAIN) & (state_nxt == IDLE);
    end
  end

endmodule
